// File: rtl/intr_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package intr_pkg;

   typedef enum logic {IDLE, REQ} state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Vector address for a channel; callers truncate to their PC width (wraps mod 2^PC_W).
   function automatic logic [31:0] vec_calc(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [31:0] id);
      return base + id * stride;
   endfunction

endpackage

// File: rtl/intr_timer.sv
// Periodic tick source: prescaler wraps at tmr_base, a second counter
// emits a one-cycle tick every tmr_thr prescaler wraps (tmr_thr = 0 stops it).
module intr_timer #(
   parameter int PRESC_W = 3,
   parameter int CNT_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PRESC_W-1:0] tmr_base,
   input  logic [CNT_W-1:0]   tmr_thr,
   output logic               tick
);

   logic [PRESC_W-1:0] presc;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               wrap;

   assign wrap    = (presc == tmr_base);
   assign cnt_inc = cnt + 1'b1;

   // A count already past a newly lowered threshold simply runs on until it wraps at 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         cnt   <= '0;
         tick  <= 1'b0;
      end else if (tmr_thr == '0) begin
         presc <= '0;
         cnt   <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= 1'b0;
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) begin
            if (cnt_inc == tmr_thr) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: synchronised edge/level sources, masking, nested
// priority service and a request/ack handshake feeding the CPU's PC mux.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int               N_IRQ      = 4,
   parameter int               PC_W       = 10,
   parameter logic [PC_W-1:0]  VEC_BASE   = 10'h3C0,
   parameter int               VEC_STRIDE = 4,
   parameter logic [N_IRQ-1:0] EDGE_MASK  = '1,
   parameter bit               TIMER_EN   = 1'b1,
   parameter int               PRESC_W    = 3,
   parameter int               CNT_W      = 4,
   localparam int              ID_W       = id_width(N_IRQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_IRQ-1:0]   irq,
   input  logic               mask_we,
   input  logic [N_IRQ-1:0]   mask_wd,
   input  logic               ei,
   input  logic               di,
   input  logic               irq_ack,
   input  logic               iret,
   input  logic [PRESC_W-1:0] tmr_base,
   input  logic [CNT_W-1:0]   tmr_thr,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   output logic [PC_W-1:0]    irq_vec,
   output logic               isr_busy
);

   // The timer channel is always edge-latched, whatever EDGE_MASK says.
   localparam logic [N_IRQ-1:0] TMR_BIT  = TIMER_EN ? {1'b1, {(N_IRQ-1){1'b0}}} : '0;
   localparam logic [N_IRQ-1:0] EDGE_SEL = EDGE_MASK | TMR_BIT;

   state_t           state, state_next;
   logic [N_IRQ-1:0] sync_a, sync_b, sync_d;
   logic [N_IRQ-1:0] src_edge, pend_edge, pending, mask, isr;
   logic [N_IRQ-1:0] eligible, ack_clr, iret_clr;
   logic             gie, tmr_tick, ack_fire, take;
   logic [ID_W-1:0]  win_id;

   function automatic logic [ID_W-1:0] prio_enc(input logic [N_IRQ-1:0] v);
      prio_enc = '0;
      for (int i = N_IRQ - 1; i >= 0; i--)
         if (v[i]) prio_enc = ID_W'(i);
   endfunction

   function automatic logic [N_IRQ-1:0] prio_above(input logic [N_IRQ-1:0] s);
      logic hit;
      hit        = 1'b0;
      prio_above = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (s[i]) hit = 1'b1;
         prio_above[i] = !hit;
      end
   endfunction

   generate
      if (TIMER_EN) begin : g_timer
         intr_timer #(.PRESC_W(PRESC_W), .CNT_W(CNT_W)) u_timer (
            .clk      (clk),
            .reset    (reset),
            .tmr_base (tmr_base),
            .tmr_thr  (tmr_thr),
            .tick     (tmr_tick)
         );
      end else begin : g_no_timer
         assign tmr_tick = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
         sync_d <= '0;
      end else begin
         sync_a <= irq;
         sync_b <= sync_a;
         sync_d <= sync_b;
      end
   end

   always_comb begin
      src_edge = sync_b & ~sync_d;
      if (TIMER_EN) src_edge[N_IRQ-1] = tmr_tick;
   end

   assign pending  = (pend_edge & EDGE_SEL) | (sync_b & ~EDGE_SEL);
   assign eligible = pending & mask & prio_above(isr);
   assign win_id   = prio_enc(eligible);
   assign take     = (state == IDLE) && gie && (|eligible);
   assign ack_fire = (state == REQ) && irq_ack;
   assign ack_clr  = ack_fire ? (N_IRQ'(1) << irq_id) : '0;
   // iret retires the lowest-index (highest-priority) in-service bit, seen before any same-cycle ack.
   assign iret_clr = iret ? (isr & ~(isr - N_IRQ'(1))) : '0;
   assign irq_req  = (state == REQ);
   assign isr_busy = |isr;

   // A fresh edge outranks an ack clearing the same channel in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend_edge <= '0;
      else       pend_edge <= ((pend_edge & ~ack_clr) | src_edge) & EDGE_SEL;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask    <= '0;
         gie     <= 1'b0;
         isr     <= '0;
         irq_id  <= '0;
         irq_vec <= '0;
      end else begin
         if (mask_we) mask <= mask_wd;
         if (di)      gie  <= 1'b0;
         else if (ei) gie  <= 1'b1;
         isr <= (isr & ~iret_clr) | ack_clr;
         if (take) begin
            irq_id  <= win_id;
            irq_vec <= PC_W'(vec_calc(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(win_id)));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Once requesting, the id/vector stay put until the CPU acks; nothing preempts or withdraws.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take)    state_next = REQ;
         REQ:     if (irq_ack) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the controller.
module tb_intr_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq, mask_wd;
   logic       mask_we, ei, di, irq_ack, iret;
   logic [2:0] tmr_base;
   logic [3:0] tmr_thr;
   logic       irq_req, isr_busy;
   logic [1:0] irq_id;
   logic [9:0] irq_vec;

   int total = 0;
   int bad   = 0;
   bit check_en;

   logic [3:0] m_s1, m_s2, m_s3, m_pend, m_mask, m_isr;
   bit         m_gie, m_req;
   int         m_id, m_vec;

   int         n_rise, last_c, n_req;
   bit         prev_req;
   logic [3:0] rnd_irq;

   always #5 clk = ~clk;

   intr_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq),
      .mask_we  (mask_we),
      .mask_wd  (mask_wd),
      .ei       (ei),
      .di       (di),
      .irq_ack  (irq_ack),
      .iret     (iret),
      .tmr_base (tmr_base),
      .tmr_thr  (tmr_thr),
      .irq_req  (irq_req),
      .irq_id   (irq_id),
      .irq_vec  (irq_vec),
      .isr_busy (isr_busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_s1 = '0; m_s2 = '0; m_s3 = '0;
      m_pend = '0; m_mask = '0; m_isr = '0;
      m_gie = 1'b0; m_req = 1'b0; m_id = 0; m_vec = 0;
   endtask

   // One clock of the controller's rules: serve the best eligible channel, nest by priority.
   task automatic modelStep();
      int top, first;
      logic [3:0] ev;
      bit fire;
      if (reset) begin
         modelReset();
         return;
      end
      top = 4;
      for (int i = 3; i >= 0; i--) if (m_isr[i]) top = i;
      first = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i] && i < top) first = i;
      fire = m_req && irq_ack;
      ev = m_s2 & ~m_s3;
      ev[3] = 1'b0;
      if (iret && top < 4) m_isr[top] = 1'b0;
      if (fire) begin
         m_isr[m_id]  = 1'b1;
         m_pend[m_id] = 1'b0;
      end
      m_pend = m_pend | ev;
      if (!m_req) begin
         if (m_gie && first >= 0) begin
            m_req = 1'b1;
            m_id  = first;
            m_vec = 'h3C0 + 4 * first;
         end
      end else if (irq_ack) begin
         m_req = 1'b0;
      end
      if (di)      m_gie = 1'b0;
      else if (ei) m_gie = 1'b1;
      if (mask_we) m_mask = mask_wd;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;
   endtask

   task automatic applyStimulus(input logic [3:0] irq_v);
      irq = irq_v;
      @(posedge clk);
      modelStep();
      #1;
      if (check_en) begin
         checkOutput("model_req",  32'(irq_req),  32'(m_req));
         checkOutput("model_id",   32'(irq_id),   32'(m_id));
         checkOutput("model_vec",  32'(irq_vec),  32'(m_vec));
         checkOutput("model_busy", 32'(isr_busy), 32'(m_isr != 4'b0));
      end
      irq_ack = 1'b0; iret = 1'b0; ei = 1'b0; di = 1'b0; mask_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; irq = '0; mask_we = 1'b0; mask_wd = '0; ei = 1'b0; di = 1'b0;
      irq_ack = 1'b0; iret = 1'b0; tmr_base = '0; tmr_thr = '0; check_en = 1'b1;
      rnd_irq = '0; prev_req = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req",  32'(irq_req),  32'd0);
      checkOutput("rst_id",   32'(irq_id),   32'd0);
      checkOutput("rst_vec",  32'(irq_vec),  32'd0);
      checkOutput("rst_busy", 32'(isr_busy), 32'd0);
      reset = 1'b0;

      // Single edge on channel 1: three-edge latency, then ack puts it in service.
      mask_we = 1'b1; mask_wd = 4'hF; ei = 1'b1; applyStimulus(4'b0000);
      applyStimulus(4'b0010);
      applyStimulus(4'b0000); applyStimulus(4'b0000);
      checkOutput("t1_noreq_k2", 32'(irq_req), 32'd0);
      applyStimulus(4'b0000);
      checkOutput("t1_req", 32'(irq_req), 32'd1);
      checkOutput("t1_id",  32'(irq_id),  32'd1);
      checkOutput("t1_vec", 32'(irq_vec), 32'h3C4);
      irq_ack = 1'b1; applyStimulus(4'b0000);
      checkOutput("t1_ack_req",  32'(irq_req),  32'd0);
      checkOutput("t1_ack_busy", 32'(isr_busy), 32'd1);
      iret = 1'b1; applyStimulus(4'b0000);
      checkOutput("t1_iret_busy", 32'(isr_busy), 32'd0);

      // Simultaneous channels 0 and 2: 0 first, 2 only after 0 retires.
      applyStimulus(4'b0101);
      repeat (3) applyStimulus(4'b0000);
      checkOutput("t2_id0",  32'(irq_id),  32'd0);
      checkOutput("t2_vec0", 32'(irq_vec), 32'h3C0);
      irq_ack = 1'b1; applyStimulus(4'b0000);
      checkOutput("t2_blocked", 32'(irq_req), 32'd0);
      iret = 1'b1; applyStimulus(4'b0000);
      checkOutput("t2_iret_edge", 32'(irq_req), 32'd0);
      applyStimulus(4'b0000);
      checkOutput("t2_req2", 32'(irq_req), 32'd1);
      checkOutput("t2_id2",  32'(irq_id),  32'd2);
      checkOutput("t2_vec2", 32'(irq_vec), 32'h3C8);
      irq_ack = 1'b1; applyStimulus(4'b0000);

      // Nesting: channel 1 preempts channel 2 in service; raw irq[3] belongs to the timer.
      applyStimulus(4'b0010);
      repeat (3) applyStimulus(4'b0000);
      checkOutput("t3_nest_req", 32'(irq_req), 32'd1);
      checkOutput("t3_nest_id",  32'(irq_id),  32'd1);
      irq_ack = 1'b1; applyStimulus(4'b0000);
      applyStimulus(4'b1000);
      repeat (5) applyStimulus(4'b0000);
      checkOutput("t3_ch3_noreq", 32'(irq_req), 32'd0);
      iret = 1'b1; applyStimulus(4'b0000);
      checkOutput("t3_iret1_busy", 32'(isr_busy), 32'd1);
      iret = 1'b1; applyStimulus(4'b0000);
      checkOutput("t3_iret2_busy", 32'(isr_busy), 32'd0);
      repeat (4) applyStimulus(4'b0000);
      checkOutput("t3_ch3_ignored", 32'(irq_req), 32'd0);

      // Masked edge stays pending and is served once the mask opens.
      mask_we = 1'b1; mask_wd = 4'h0; applyStimulus(4'b0000);
      applyStimulus(4'b0010);
      repeat (5) applyStimulus(4'b0000);
      checkOutput("t4_masked", 32'(irq_req), 32'd0);
      mask_we = 1'b1; mask_wd = 4'b0010; applyStimulus(4'b0000);
      checkOutput("t4_mask_lag", 32'(irq_req), 32'd0);
      applyStimulus(4'b0000);
      checkOutput("t4_req", 32'(irq_req), 32'd1);
      checkOutput("t4_id",  32'(irq_id),  32'd1);
      irq_ack = 1'b1; applyStimulus(4'b0000);
      iret = 1'b1; applyStimulus(4'b0000);

      // Timer on channel 3: base 3, threshold 2 -> one request every 8 clocks.
      mask_we = 1'b1; mask_wd = 4'hF; applyStimulus(4'b0000);
      check_en = 1'b0;
      tmr_base = 3'd3; tmr_thr = 4'd2;
      n_rise = 0; last_c = 0; prev_req = 1'b0;
      for (int c = 0; c < 80 && n_rise < 4; c++) begin
         irq_ack = 1'b1; iret = 1'b1;
         applyStimulus(4'b1000);
         if (irq_req && !prev_req) begin
            if (n_rise > 0) checkOutput("t5_period", 32'(c - last_c), 32'd8);
            checkOutput("t5_id",  32'(irq_id),  32'd3);
            checkOutput("t5_vec", 32'(irq_vec), 32'h3CC);
            last_c = c;
            n_rise++;
         end
         prev_req = irq_req;
      end
      checkOutput("t5_count", 32'(n_rise), 32'd4);
      tmr_thr = 4'd0;
      repeat (6) begin
         irq_ack = 1'b1; iret = 1'b1;
         applyStimulus(4'b0000);
      end
      n_req = 0;
      for (int c = 0; c < 30; c++) begin
         applyStimulus(4'b0000);
         if (irq_req) n_req++;
      end
      checkOutput("t5_off", 32'(n_req), 32'd0);

      // Async reset while requesting clears everything at once, with nothing stale afterwards.
      reset = 1'b1; modelReset(); #1; reset = 1'b0;
      check_en = 1'b1;
      mask_we = 1'b1; mask_wd = 4'hF; ei = 1'b1; applyStimulus(4'b0000);
      applyStimulus(4'b0001); applyStimulus(4'b0100);
      applyStimulus(4'b0000); applyStimulus(4'b0000);
      checkOutput("t6_pre_req", 32'(irq_req), 32'd1);
      checkOutput("t6_pre_id",  32'(irq_id),  32'd0);
      #2; reset = 1'b1; modelReset(); #1;
      checkOutput("t6_async_req",  32'(irq_req),  32'd0);
      checkOutput("t6_async_id",   32'(irq_id),   32'd0);
      checkOutput("t6_async_vec",  32'(irq_vec),  32'd0);
      checkOutput("t6_async_busy", 32'(isr_busy), 32'd0);
      @(posedge clk); #1; reset = 1'b0;
      mask_we = 1'b1; mask_wd = 4'hF; ei = 1'b1; applyStimulus(4'b0000);
      repeat (6) applyStimulus(4'b0000);
      checkOutput("t6_no_stale", 32'(irq_req), 32'd0);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) rnd_irq[b] = ~rnd_irq[b];
         irq_ack = m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
         iret    = ($urandom_range(0, 7) == 0);
         ei      = ($urandom_range(0, 5) == 0);
         di      = ($urandom_range(0, 11) == 0);
         mask_we = ($urandom_range(0, 15) == 0);
         mask_wd = 4'($urandom);
         applyStimulus(rnd_irq);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
